// File: rtl/fir_seq_ctrl_pkg.sv
// Shared types and widths for the folded FIR scheduler.
// Holds FSM encodings, default widths and the accumulator sizing rule.
package fir_seq_ctrl_pkg;

  localparam int IN_WL  = 15;
  localparam int MAC_WL = 20;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MAC  = 2'd1,
    S_OUT  = 2'd2
  } state_e;

  // Full product plus AW guard bits: NTAP <= 2^AW sums cannot overflow.
  function automatic int acc_width(input int in_wl, input int aw);
    return 2 * in_wl + aw;
  endfunction

endpackage

// File: rtl/fir_seq_ctrl_mac_unit.sv
// Shared signed multiply-accumulate with clear, shift and saturation.
// The result is formed from the sum that includes the current product.
module fir_mac_unit
  import fir_seq_ctrl_pkg::*;
#(
  parameter int inWL      = IN_WL,
  parameter int macWL     = MAC_WL,
  parameter int AW        = 6,
  parameter int OUT_SHIFT = 0
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    acc_clr,
  input  logic                    acc_en,
  input  logic signed [inWL-1:0]  coef,
  input  logic signed [inWL-1:0]  samp,
  output logic signed [macWL-1:0] res,
  output logic                    res_sat
);

  localparam int ACCW = acc_width(inWL, AW);
  localparam int PW   = 2 * inWL;

  localparam logic signed [ACCW-1:0] SAT_MAX =
    {{(ACCW-macWL+1){1'b0}}, {(macWL-1){1'b1}}};
  localparam logic signed [ACCW-1:0] SAT_MIN =
    {{(ACCW-macWL+1){1'b1}}, {(macWL-1){1'b0}}};

  logic signed [PW-1:0]   coef_x;
  logic signed [PW-1:0]   samp_x;
  logic signed [PW-1:0]   prod;
  logic signed [ACCW-1:0] acc_q;
  logic signed [ACCW-1:0] acc_d;
  logic signed [ACCW-1:0] acc_sum;
  logic signed [ACCW-1:0] shifted;

  assign coef_x  = {{inWL{coef[inWL-1]}}, coef};
  assign samp_x  = {{inWL{samp[inWL-1]}}, samp};
  assign prod    = coef_x * samp_x;
  assign acc_sum = acc_q + {{(ACCW-PW){prod[PW-1]}}, prod};
  assign shifted = acc_sum >>> OUT_SHIFT;

  always_comb begin
    acc_d = acc_q;
    if (acc_clr) begin
      acc_d = '0;
    end else if (acc_en) begin
      acc_d = acc_sum;
    end
  end

  always_comb begin
    res     = shifted[macWL-1:0];
    res_sat = 1'b0;
    if (shifted > SAT_MAX) begin
      res     = SAT_MAX[macWL-1:0];
      res_sat = 1'b1;
    end else if (shifted < SAT_MIN) begin
      res     = SAT_MIN[macWL-1:0];
      res_sat = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

endmodule

// File: rtl/fir_seq_ctrl.sv
// Folded FIR scheduler: one MAC walks NTAP taps per accepted sample.
// Owns the circular delay line, coefficient file and both handshakes.
module fir_seq_ctrl
  import fir_seq_ctrl_pkg::*;
#(
  parameter int NTAP      = 16,
  parameter int inWL      = IN_WL,
  parameter int macWL     = MAC_WL,
  parameter int OUT_SHIFT = 0,
  parameter int AW        = 6
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic signed [inWL-1:0]  in_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [macWL-1:0] out_data,
  output logic                    out_sat,
  input  logic                    cfg_we,
  input  logic [AW-1:0]           cfg_addr,
  input  logic signed [inWL-1:0]  cfg_data,
  input  logic                    clr,
  output logic                    cfg_err,
  output logic                    busy
);

  localparam logic [AW-1:0] LAST   = AW'(NTAP - 1);
  localparam logic [AW:0]   NTAP_W = (AW+1)'(NTAP);

  state_e state_q, state_d;

  logic [AW-1:0] k_q, k_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;

  logic signed [inWL-1:0] dly_q  [NTAP];
  logic signed [inWL-1:0] dly_d  [NTAP];
  logic signed [inWL-1:0] coef_q [NTAP];
  logic signed [inWL-1:0] coef_d [NTAP];

  logic signed [macWL-1:0] out_data_q, out_data_d;
  logic                    out_sat_q, out_sat_d;
  logic                    cfg_err_q, cfg_err_d;

  logic                    idle;
  logic                    cfg_ok;
  logic                    acc_clr;
  logic                    acc_en;
  logic signed [inWL-1:0]  coef_rd;
  logic signed [inWL-1:0]  samp_rd;
  logic signed [macWL-1:0] mac_res;
  logic                    mac_sat;

  assign idle      = (state_q == S_IDLE);
  assign cfg_ok    = cfg_we && idle && ({1'b0, cfg_addr} < NTAP_W);
  assign in_ready  = idle && !clr;
  assign busy      = !idle;
  assign out_valid = (state_q == S_OUT);
  assign out_data  = out_data_q;
  assign out_sat   = out_sat_q;
  assign cfg_err   = cfg_err_q;

  // Compare-based read muxes keep NTAP free of power-of-two limits.
  always_comb begin
    coef_rd = '0;
    samp_rd = '0;
    for (int i = 0; i < NTAP; i++) begin
      if (k_q == AW'(i)) coef_rd = coef_q[i];
      if (rd_ptr_q == AW'(i)) samp_rd = dly_q[i];
    end
  end

  fir_mac_unit #(
    .inWL      (inWL),
    .macWL     (macWL),
    .AW        (AW),
    .OUT_SHIFT (OUT_SHIFT)
  ) u_mac (
    .clk     (clk),
    .rst_n   (rst_n),
    .acc_clr (acc_clr),
    .acc_en  (acc_en),
    .coef    (coef_rd),
    .samp    (samp_rd),
    .res     (mac_res),
    .res_sat (mac_sat)
  );

  always_comb begin
    state_d    = state_q;
    k_d        = k_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    dly_d      = dly_q;
    coef_d     = coef_q;
    out_data_d = out_data_q;
    out_sat_d  = out_sat_q;
    cfg_err_d  = (cfg_we && !cfg_ok) || (clr && !idle);
    acc_clr    = 1'b0;
    acc_en     = 1'b0;

    if (cfg_ok) begin
      for (int i = 0; i < NTAP; i++) begin
        if (cfg_addr == AW'(i)) coef_d[i] = cfg_data;
      end
    end

    unique case (state_q)
      S_IDLE: begin
        if (clr) begin
          wr_ptr_d = '0;
          for (int i = 0; i < NTAP; i++) dly_d[i] = '0;
        end else if (in_valid) begin
          for (int i = 0; i < NTAP; i++) begin
            if (wr_ptr_q == AW'(i)) dly_d[i] = in_data;
          end
          acc_clr  = 1'b1;
          k_d      = '0;
          rd_ptr_d = wr_ptr_q;
          state_d  = S_MAC;
        end
      end
      S_MAC: begin
        acc_en   = 1'b1;
        k_d      = k_q + 1'b1;
        rd_ptr_d = (rd_ptr_q == '0) ? LAST : rd_ptr_q - 1'b1;
        if (k_q == LAST) begin
          state_d    = S_OUT;
          out_data_d = mac_res;
          out_sat_d  = mac_sat;
          wr_ptr_d   = (wr_ptr_q == LAST) ? '0 : wr_ptr_q + 1'b1;
        end
      end
      S_OUT: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      k_q        <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      out_data_q <= '0;
      out_sat_q  <= 1'b0;
      cfg_err_q  <= 1'b0;
      for (int i = 0; i < NTAP; i++) begin
        dly_q[i]  <= '0;
        coef_q[i] <= '0;
      end
    end else begin
      state_q    <= state_d;
      k_q        <= k_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      out_data_q <= out_data_d;
      out_sat_q  <= out_sat_d;
      cfg_err_q  <= cfg_err_d;
      dly_q      <= dly_d;
      coef_q     <= coef_d;
    end
  end

endmodule

// File: tb/tb_fir_seq_ctrl.sv
// Directed bench for fir_seq_ctrl: vector tables plus hand sequences.
// A shift-register FIR model covers the random stream.
module tb_fir_seq_ctrl;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               in_valid;
  logic               in_ready;
  logic signed [14:0] in_data;
  logic               out_valid;
  logic               out_ready;
  logic signed [19:0] out_data;
  logic               out_sat;
  logic               cfg_we;
  logic [5:0]         cfg_addr;
  logic signed [14:0] cfg_data;
  logic               clr;
  logic               cfg_err;
  logic               busy;

  int tests = 0;
  int fails = 0;

  longint hist  [16];
  longint mcoef [16];

  typedef struct {
    logic signed [14:0] x;
    longint             exp_y;
    logic               exp_s;
  } vec_t;

  vec_t imp_tbl [20];
  vec_t sat_tbl [32];

  fir_seq_ctrl u_dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_sat   (out_sat),
    .cfg_we    (cfg_we),
    .cfg_addr  (cfg_addr),
    .cfg_data  (cfg_data),
    .clr       (clr),
    .cfg_err   (cfg_err),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input longint got,
                       input longint exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic model_clr();
    for (int k = 0; k < 16; k++) hist[k] = 0;
  endtask

  task automatic model_step(input longint x, output longint y,
                            output logic s);
    longint acc;
    for (int k = 15; k > 0; k--) hist[k] = hist[k-1];
    hist[0] = x;
    acc = 0;
    for (int k = 0; k < 16; k++) acc += mcoef[k] * hist[k];
    s = 1'b1;
    if (acc > 524287) y = 524287;
    else if (acc < -524288) y = -524288;
    else begin
      y = acc;
      s = 1'b0;
    end
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    if (busy) check("idle_timeout", 1, 0);
  endtask

  task automatic wait_out(output int lat);
    lat = 0;
    do begin
      @(posedge clk); #1;
      lat++;
    end while (!out_valid && lat < 100);
    if (!out_valid) check("out_valid_timeout", 0, 1);
  endtask

  task automatic send(input logic signed [14:0] x, output longint y,
                      output logic s, output int lat,
                      output longint my, output logic ms);
    int n = 0;
    while (!in_ready && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    if (!in_ready) check("in_ready_timeout", 0, 1);
    in_valid = 1'b1;
    in_data  = x;
    @(posedge clk); #1;
    in_valid = 1'b0;
    model_step(longint'(x), my, ms);
    wait_out(lat);
    y = out_data;
    s = out_sat;
  endtask

  task automatic cfg_write(input int addr, input int data,
                           input logic exp_err);
    wait_idle();
    cfg_we   = 1'b1;
    cfg_addr = 6'(addr);
    cfg_data = 15'(data);
    @(posedge clk); #1;
    cfg_we = 1'b0;
    check("cfg_err_write", cfg_err, exp_err);
    if (addr < 16) mcoef[addr] = longint'(15'(data) - 15'sd0);
  endtask

  task automatic clr_dut();
    wait_idle();
    clr      = 1'b1;
    in_valid = 1'b1;
    in_data  = 15'sd9;
    #1;
    check("clr_in_ready", in_ready, 0);
    @(posedge clk); #1;
    clr      = 1'b0;
    in_valid = 1'b0;
    check("clr_no_accept", busy, 0);
    check("clr_cfg_err", cfg_err, 0);
    model_clr();
  endtask

  initial begin
    longint y, my;
    logic   s, ms;
    int     lat;

    for (int i = 0; i < 20; i++) begin
      imp_tbl[i].x     = (i == 0) ? 15'sd1 : 15'sd0;
      imp_tbl[i].exp_y = (i < 16) ? longint'(i + 1) : 0;
      imp_tbl[i].exp_s = 1'b0;
    end
    for (int i = 0; i < 16; i++) begin
      sat_tbl[i].x        = 15'sd16383;
      sat_tbl[i].exp_y    = 524287;
      sat_tbl[i].exp_s    = 1'b1;
      sat_tbl[16+i].x     = -15'sd16384;
      sat_tbl[16+i].exp_y = -524288;
      sat_tbl[16+i].exp_s = 1'b1;
    end
    for (int k = 0; k < 16; k++) mcoef[k] = 0;
    model_clr();

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b1;
    cfg_we    = 1'b0;
    cfg_addr  = '0;
    cfg_data  = '0;
    clr       = 1'b0;
    #12;
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_out_sat", out_sat, 0);
    check("rst_cfg_err", cfg_err, 0);
    check("rst_busy", busy, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    for (int k = 0; k < 16; k++) cfg_write(k, k + 1, 1'b0);
    for (int i = 0; i < 20; i++) begin
      send(imp_tbl[i].x, y, s, lat, my, ms);
      check($sformatf("imp_y[%0d]", i), y, imp_tbl[i].exp_y);
      check($sformatf("imp_sat[%0d]", i), s, imp_tbl[i].exp_s);
      check($sformatf("imp_lat[%0d]", i), lat, 16);
    end

    wait_idle();
    out_ready = 1'b0;
    send(15'sd5, y, s, lat, my, ms);
    check("bp_first", y, 5);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      check("bp_hold_data", out_data, 5);
      check("bp_hold_valid", out_valid, 1);
      check("bp_in_ready", in_ready, 0);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    check("bp_release_ready", in_ready, 1);
    check("bp_release_valid", out_valid, 0);
    send(15'sd0, y, s, lat, my, ms);
    check("bp_next", y, 10);

    clr_dut();
    in_valid = 1'b1;
    in_data  = 15'sd3;
    @(posedge clk); #1;
    in_valid = 1'b0;
    model_step(3, my, ms);
    cfg_we   = 1'b1;
    cfg_addr = 6'd3;
    cfg_data = 15'sd999;
    @(posedge clk); #1;
    cfg_we = 1'b0;
    check("busy_cfg_err", cfg_err, 1);
    @(posedge clk); #1;
    check("busy_cfg_err_pulse", cfg_err, 0);
    clr = 1'b1;
    @(posedge clk); #1;
    clr = 1'b0;
    check("busy_clr_err", cfg_err, 1);
    wait_out(lat);
    check("busy_out", out_data, 3);
    check("busy_out_model", out_data, my);
    cfg_write(20, 555, 1'b1);
    clr_dut();
    for (int i = 0; i < 4; i++) begin
      send((i == 0) ? 15'sd1 : 15'sd0, y, s, lat, my, ms);
      check($sformatf("coef_keep[%0d]", i), y, i + 1);
    end

    clr_dut();
    cfg_we   = 1'b1;
    cfg_addr = 6'd0;
    cfg_data = 15'sd7;
    in_valid = 1'b1;
    in_data  = 15'sd1;
    @(posedge clk); #1;
    cfg_we   = 1'b0;
    in_valid = 1'b0;
    mcoef[0] = 7;
    model_step(1, my, ms);
    wait_out(lat);
    check("same_cycle_write", out_data, 7);
    cfg_write(0, 1, 1'b0);

    for (int i = 0; i < 40; i++) begin
      int r;
      r = int'($urandom_range(32767, 0)) - 16384;
      send(15'(r), y, s, lat, my, ms);
      check($sformatf("rand_y[%0d]", i), y, my);
      check($sformatf("rand_sat[%0d]", i), s, ms);
    end
    clr_dut();
    send(15'sd1, y, s, lat, my, ms);
    check("clr_impulse", y, 1);

    for (int k = 0; k < 16; k++) cfg_write(k, 16383, 1'b0);
    for (int i = 0; i < 32; i++) begin
      if (i % 16 == 0) clr_dut();
      send(sat_tbl[i].x, y, s, lat, my, ms);
      check($sformatf("sat_y[%0d]", i), y, sat_tbl[i].exp_y);
      check($sformatf("sat_s[%0d]", i), s, sat_tbl[i].exp_s);
    end

    wait_idle();
    in_valid = 1'b1;
    in_data  = 15'sd1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (7) @(posedge clk);
    #1;
    check("mid_mac_busy", busy, 1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_busy", busy, 0);
    check("mid_rst_in_ready", in_ready, 1);
    check("mid_rst_out_valid", out_valid, 0);
    check("mid_rst_out_data", out_data, 0);
    check("mid_rst_out_sat", out_sat, 0);
    check("mid_rst_cfg_err", cfg_err, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int k = 0; k < 16; k++) mcoef[k] = 0;
    model_clr();
    send(15'sd1, y, s, lat, my, ms);
    check("post_rst_impulse", y, 0);
    check("post_rst_sat", s, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/fir_seq_ctrl.md
Name: fir_seq_ctrl

Overview:
Folded FIR scheduler. It owns one shared multiply-accumulate unit, the sample delay line (circular buffer) and the coefficient register file. For each accepted input sample it sequences NTAP multiply-accumulate cycles, then presents one result on a valid/ready output. Coefficients are written from a configuration port. It is a lower-area alternative to the direct-form fir block, with the same 15-bit input and 20-bit output widths.

Parameters:
NTAP, 16, number of taps (2..64); need not be a power of two
inWL, 15, signed sample and coefficient width
macWL, 20, signed output width
OUT_SHIFT, 0, arithmetic right shift applied to the accumulator before saturation
AW, 6, address width for the tap index and cfg_addr; must satisfy 2^AW >= NTAP

Ports:
clk  in  1  single clock, rising edge
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  input sample valid
in_ready  out  1  block can accept a sample
in_data  in  inWL  signed input sample
out_valid  out  1  result valid
out_ready  in  1  downstream accepts result
out_data  out  macWL  signed saturated result
out_sat  out  1  result was saturated; qualified by out_valid
cfg_we  in  1  coefficient write strobe
cfg_addr  in  AW  tap index
cfg_data  in  inWL  signed coefficient
clr  in  1  zero the delay line
cfg_err  out  1  one-cycle pulse: cfg_we or clr was rejected
busy  out  1  state is not IDLE

Behaviour:
- Reset (asynchronous, any state, including mid-MAC): state=IDLE, in_ready=1, out_valid=0, out_data=0, out_sat=0, cfg_err=0, busy=0, wr_ptr=0, accumulator=0, all delay-line entries 0, all coefficients 0. An in-flight computation is discarded.
- FSM states: IDLE, MAC, OUT.
- IDLE: in_ready=1.
  - At the edge T where in_valid&&in_ready: buf[wr_ptr]<=in_data, acc<=0, k<=0, go to MAC.
- MAC: runs exactly NTAP cycles, k=0..NTAP-1.
  - Each cycle: acc += coef[k]*buf[(wr_ptr-k) mod NTAP].
  - Index wrap is by compare-and-subtract, not power-of-two masking.
  - On the edge with k=NTAP-1 (T+NTAP): go to OUT; out_data<=sat(acc_final>>>OUT_SHIFT); out_sat set; out_valid<=1; wr_ptr<=(wr_ptr==NTAP-1)?0:wr_ptr+1.
  - out_valid is therefore visible after edge T+NTAP; latency is NTAP cycles from acceptance.
- OUT: holds out_data, out_sat and out_valid stable while out_ready=0.
  - On out_valid&&out_ready, go to IDLE; in_ready is high the next cycle.
  - Minimum sample period is NTAP+1 cycles.
- Arithmetic:
  - Product is 2*inWL bits signed.
  - Accumulator is 2*inWL+AW bits, so no internal overflow.
  - Saturate to [-2^(macWL-1), 2^(macWL-1)-1].
  - out_sat=1 iff clipping occurred.
- Configuration:
  - cfg_we is honoured only in IDLE and only when cfg_addr<NTAP.
  - If a write and a sample handshake occur in the same cycle, both take effect; the new coefficient is used by that sample.
  - cfg_we in MAC or OUT, or with cfg_addr>=NTAP: no write, cfg_err pulses one cycle.
- clr:
  - In IDLE: zeroes every buf entry and wr_ptr next edge; coefficients are unchanged.
  - clr has priority over a simultaneous sample handshake; that sample is not accepted and in_ready is forced 0 that cycle.
  - clr outside IDLE: ignored, cfg_err pulses.
- busy = (state!=IDLE).

Decomposition:
- Shared include fir_defs.vh holds:
  - FSM state encodings (IDLE=2'd0, MAC=2'd1, OUT=2'd2)
  - default widths inWL=15 and macWL=20
  - the accumulator width formula
- One sub-module, fir_mac_unit, contains:
  - the signed multiplier
  - the accumulator with synchronous clear
  - the shift and saturation output stage
- fir_seq_ctrl holds the FSM, counters, circular buffer, coefficient file and handshakes.

Test Plan:
- Impulse response: coef[k]=k+1 for k=0..15; input 1 followed by 19 zeros, out_ready=1 -> out_data sequence 1,2,...,16 then 0,0,0,0; out_sat=0; each out_valid asserts NTAP cycles after acceptance.
- Backpressure: hold out_ready=0 for 10 cycles after out_valid -> out_data stable, in_ready=0 throughout; release -> in_ready=1 on the next cycle; no sample is lost or duplicated.
- Saturation: all coefficients 16383; feed 16 samples of 16383 -> 16th output is 524287 with out_sat=1. Repeat with input -16384 -> -524288, out_sat=1.
- Config while busy: cfg_we with cfg_addr=3 during MAC, and cfg_addr=20 in IDLE -> cfg_err pulses once each, coef[3] unchanged, subsequent outputs unchanged.
- Wrap and clr: stream 40 random samples, compared against a golden model -> all match across wr_ptr wrap. Then assert clr in IDLE and send an impulse -> output equals coef[0] only.
- Reset mid-MAC: deassert rst_n at MAC k=7 -> all outputs go to their reset values immediately; after release, an impulse yields 0, since coefficients are cleared.
